// File: rtl/ex_stage.sv
// Execute stage of the 16-bit pipeline: operand forwarding, ALU, branch/jump
// resolution, PC redirect with one-slot squash, and the EX/MEM register.
module ex_stage (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        RegWrite1,
  input  logic        MemotoReg1,
  input  logic        MemWrite1,
  input  logic        MemRead1,
  input  logic [3:0]  AluOp1,
  input  logic [15:0] PcAddr1,
  input  logic [15:0] RegData11,
  input  logic [15:0] RegData21,
  input  logic [3:0]  RegReadIndex11,
  input  logic [3:0]  RegReadIndex21,
  input  logic [3:0]  RegWriteIndex1,
  input  logic        InsJ1,
  input  logic [1:0]  InsB1,
  input  logic        AluSrc1,
  input  logic [15:0] Dest1,
  input  logic        WbRegWrite,
  input  logic [3:0]  WbIndex,
  input  logic [15:0] WbData,
  input  logic        Stall,
  output logic        Redirect,
  output logic [15:0] RedirectAddr,
  output logic        ExRegWrite,
  output logic        ExMemtoReg,
  output logic        ExMemWrite,
  output logic        ExMemRead,
  output logic [15:0] ExResult,
  output logic [15:0] ExStoreData,
  output logic [3:0]  ExWriteIndex
);

  typedef enum logic {SQ_IDLE = 1'b0, SQ_ARMED = 1'b1} squash_e;

  squash_e     r_squash, w_squash_next;
  logic [15:0] w_fwd_a, w_fwd_b, w_op_b, w_alu;
  logic        w_taken, w_kill;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_fwd_a = RegData11;
    if (ExRegWrite && !ExMemtoReg && ExWriteIndex == RegReadIndex11)
      w_fwd_a = ExResult;
    else if (WbRegWrite && WbIndex == RegReadIndex11)
      w_fwd_a = WbData;
  end

  always_comb begin
    w_fwd_b = RegData21;
    if (ExRegWrite && !ExMemtoReg && ExWriteIndex == RegReadIndex21)
      w_fwd_b = ExResult;
    else if (WbRegWrite && WbIndex == RegReadIndex21)
      w_fwd_b = WbData;
  end

  assign w_op_b = AluSrc1 ? Dest1 : w_fwd_b;

  always_comb begin
    w_alu = 16'h0000;
    case (AluOp1)
      4'd0:  w_alu = w_fwd_a + w_op_b;
      4'd1:  w_alu = w_fwd_a - w_op_b;
      4'd2:  w_alu = w_fwd_a & w_op_b;
      4'd3:  w_alu = w_fwd_a | w_op_b;
      4'd4:  w_alu = w_fwd_a ^ w_op_b;
      4'd5:  w_alu = ~w_fwd_a;
      4'd6:  w_alu = w_fwd_a << w_op_b[3:0];
      4'd7:  w_alu = w_fwd_a >> w_op_b[3:0];
      4'd8:  w_alu = $signed(w_fwd_a) >>> w_op_b[3:0];
      4'd9:  w_alu = {15'd0, $signed(w_fwd_a) < $signed(w_op_b)};
      4'd10: w_alu = {15'd0, w_fwd_a < w_op_b};
      4'd11: w_alu = {15'd0, w_fwd_a != w_op_b};
      4'd12: w_alu = w_fwd_a;
      4'd13: w_alu = w_op_b;
      default: w_alu = 16'h0000;
    endcase
  end

  // A register jump overrides any branch encoding on the same instruction.
  always_comb begin
    w_taken = 1'b0;
    if (InsJ1)
      w_taken = 1'b1;
    else begin
      case (InsB1)
        2'b01:   w_taken = (w_fwd_a == 16'h0000);
        2'b10:   w_taken = (w_fwd_a != 16'h0000);
        2'b11:   w_taken = 1'b1;
        default: w_taken = 1'b0;
      endcase
    end
  end

  assign w_kill       = (r_squash == SQ_ARMED);
  assign RedirectAddr = InsJ1 ? w_fwd_a : PcAddr1 + Dest1;
  assign Redirect     = w_taken && !w_kill && !Stall && Rst;

  always_comb begin
    w_squash_next = r_squash;
    case (r_squash)
      SQ_IDLE:  if (!Stall && Redirect) w_squash_next = SQ_ARMED;
      SQ_ARMED: if (!Stall)             w_squash_next = SQ_IDLE;
      default:  w_squash_next = SQ_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_squash <= SQ_IDLE;
    else      r_squash <= w_squash_next;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ExRegWrite   <= 1'b0;
      ExMemtoReg   <= 1'b0;
      ExMemWrite   <= 1'b0;
      ExMemRead    <= 1'b0;
      ExResult     <= 16'h0000;
      ExStoreData  <= 16'h0000;
      ExWriteIndex <= 4'h0;
    end else if (!Stall) begin
      ExRegWrite   <= RegWrite1  && !w_kill;
      ExMemtoReg   <= MemotoReg1 && !w_kill;
      ExMemWrite   <= MemWrite1  && !w_kill;
      ExMemRead    <= MemRead1   && !w_kill;
      ExResult     <= w_alu;
      ExStoreData  <= w_fwd_b;
      ExWriteIndex <= RegWriteIndex1;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus random instructions
// compared against a behavioural model of the execute stage.
module tb_ex_stage;

  logic        Clk, Rst;
  logic        RegWrite1, MemotoReg1, MemWrite1, MemRead1;
  logic [3:0]  AluOp1;
  logic [15:0] PcAddr1, RegData11, RegData21;
  logic [3:0]  RegReadIndex11, RegReadIndex21, RegWriteIndex1;
  logic        InsJ1;
  logic [1:0]  InsB1;
  logic        AluSrc1;
  logic [15:0] Dest1;
  logic        WbRegWrite;
  logic [3:0]  WbIndex;
  logic [15:0] WbData;
  logic        Stall;
  logic        Redirect;
  logic [15:0] RedirectAddr;
  logic        ExRegWrite, ExMemtoReg, ExMemWrite, ExMemRead;
  logic [15:0] ExResult, ExStoreData;
  logic [3:0]  ExWriteIndex;

  int checks = 0;
  int errors = 0;

  // Model of EX/MEM contents and the squash flag.
  logic        m_rw, m_mtr, m_mw, m_mr, m_sq;
  logic [15:0] m_res, m_sd;
  logic [3:0]  m_wi;

  ex_stage dut (
    .Clk(Clk), .Rst(Rst),
    .RegWrite1(RegWrite1), .MemotoReg1(MemotoReg1), .MemWrite1(MemWrite1), .MemRead1(MemRead1),
    .AluOp1(AluOp1), .PcAddr1(PcAddr1), .RegData11(RegData11), .RegData21(RegData21),
    .RegReadIndex11(RegReadIndex11), .RegReadIndex21(RegReadIndex21), .RegWriteIndex1(RegWriteIndex1),
    .InsJ1(InsJ1), .InsB1(InsB1), .AluSrc1(AluSrc1), .Dest1(Dest1),
    .WbRegWrite(WbRegWrite), .WbIndex(WbIndex), .WbData(WbData), .Stall(Stall),
    .Redirect(Redirect), .RedirectAddr(RedirectAddr),
    .ExRegWrite(ExRegWrite), .ExMemtoReg(ExMemtoReg), .ExMemWrite(ExMemWrite), .ExMemRead(ExMemRead),
    .ExResult(ExResult), .ExStoreData(ExStoreData), .ExWriteIndex(ExWriteIndex)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] fwd(input logic [3:0] idx, input logic [15:0] rf);
    if (m_rw && !m_mtr && m_wi == idx) return m_res;
    if (WbRegWrite && WbIndex == idx)  return WbData;
    return rf;
  endfunction

  function automatic logic [15:0] alu_ref(input int op, input logic [15:0] a, input logic [15:0] b);
    int ua, ub, sa, sb, sh;
    ua = int'(a); ub = int'(b);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    sh = ub % 16;
    case (op)
      0:  return 16'((ua + ub) % 65536);
      1:  return 16'((ua - ub + 65536) % 65536);
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return 16'(65535 - ua);
      6:  return 16'((ua * (1 << sh)) % 65536);
      7:  return 16'(ua / (1 << sh));
      8:  return 16'(sa >>> sh);
      9:  return (sa < sb) ? 16'd1 : 16'd0;
      10: return (ua < ub) ? 16'd1 : 16'd0;
      11: return (ua == ub) ? 16'd0 : 16'd1;
      12: return a;
      13: return b;
      default: return 16'd0;
    endcase
  endfunction

  task automatic model_clear();
    m_rw = 0; m_mtr = 0; m_mw = 0; m_mr = 0; m_sq = 0;
    m_res = 0; m_sd = 0; m_wi = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".regwrite"}, {15'd0, ExRegWrite}, {15'd0, m_rw});
    check({tag, ".memtoreg"}, {15'd0, ExMemtoReg}, {15'd0, m_mtr});
    check({tag, ".memwrite"}, {15'd0, ExMemWrite}, {15'd0, m_mw});
    check({tag, ".memread"},  {15'd0, ExMemRead},  {15'd0, m_mr});
    check({tag, ".result"},   ExResult, m_res);
    check({tag, ".store"},    ExStoreData, m_sd);
    check({tag, ".windex"},   {12'd0, ExWriteIndex}, {12'd0, m_wi});
  endtask

  // Called just after a rising edge with ID/EX inputs already driven.
  task automatic step(input string tag);
    logic [15:0] fa, fb, opb, tgt;
    logic        taken, red;
    #1;
    fa    = fwd(RegReadIndex11, RegData11);
    fb    = fwd(RegReadIndex21, RegData21);
    opb   = AluSrc1 ? Dest1 : fb;
    taken = InsJ1 || InsB1 == 2'b11 || (InsB1 == 2'b01 && fa == 0) || (InsB1 == 2'b10 && fa != 0);
    tgt   = InsJ1 ? fa : 16'((int'(PcAddr1) + int'(Dest1)) % 65536);
    red   = taken && !m_sq && !Stall && Rst;
    check({tag, ".redirect"}, {15'd0, Redirect}, {15'd0, red});
    check({tag, ".raddr"}, RedirectAddr, tgt);
    @(posedge Clk);
    if (!Stall) begin
      m_rw  = RegWrite1  && !m_sq;
      m_mtr = MemotoReg1 && !m_sq;
      m_mw  = MemWrite1  && !m_sq;
      m_mr  = MemRead1   && !m_sq;
      m_res = alu_ref(int'(AluOp1), fa, opb);
      m_sd  = fb;
      m_wi  = RegWriteIndex1;
      m_sq  = red;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic nop();
    RegWrite1 = 0; MemotoReg1 = 0; MemWrite1 = 0; MemRead1 = 0;
    AluOp1 = 4'd15; PcAddr1 = 16'h0100; RegData11 = 0; RegData21 = 0;
    RegReadIndex11 = 4'd0; RegReadIndex21 = 4'd0; RegWriteIndex1 = 4'd0;
    InsJ1 = 0; InsB1 = 2'b00; AluSrc1 = 0; Dest1 = 0;
    WbRegWrite = 0; WbIndex = 0; WbData = 0; Stall = 0;
  endtask

  initial begin
    Rst = 1'b0;
    nop();
    model_clear();
    #2;
    check_outputs("reset");
    check("reset.redirect", {15'd0, Redirect}, 16'd0);
    Rst = 1'b1;

    // ADD R4 = 3 + 5
    nop(); RegData11 = 16'h0003; RegData21 = 16'h0005; AluOp1 = 4'd0;
    RegWrite1 = 1; RegWriteIndex1 = 4'd4; RegReadIndex11 = 4'd1; RegReadIndex21 = 4'd2;
    step("add");
    check("add.lit", ExResult, 16'h0008);

    // SUB forwarding from EX/MEM
    nop(); AluOp1 = 4'd1; RegReadIndex11 = 4'd4; RegData11 = 0; RegReadIndex21 = 4'd2;
    RegData21 = 16'h0001; RegWrite1 = 1; RegWriteIndex1 = 4'd5;
    step("fwd_ex");
    check("fwd_ex.lit", ExResult, 16'h0007);

    // MEM/WB-only match
    nop(); AluOp1 = 4'd1; RegReadIndex11 = 4'd4; RegReadIndex21 = 4'd2; RegData21 = 16'h0001;
    WbRegWrite = 1; WbIndex = 4'd4; WbData = 16'h0010; RegWrite1 = 1; RegWriteIndex1 = 4'd6;
    step("fwd_wb");
    check("fwd_wb.lit", ExResult, 16'h000F);

    // Both stages match R6: EX/MEM value (0x000F) wins
    nop(); AluOp1 = 4'd1; RegReadIndex11 = 4'd6; RegReadIndex21 = 4'd2; RegData21 = 16'h0001;
    WbRegWrite = 1; WbIndex = 4'd6; WbData = 16'h0100;
    step("fwd_both");
    check("fwd_both.lit", ExResult, 16'h000E);

    // BEQZ taken, then squashed slot, then normal instruction
    nop(); InsB1 = 2'b01; RegReadIndex11 = 4'd9; PcAddr1 = 16'h0010; Dest1 = 16'hFFFE;
    step("beqz");
    nop(); RegWrite1 = 1; MemWrite1 = 1; AluOp1 = 4'd12; RegData11 = 16'h0055;
    step("squashed");
    check("squashed.lit", {15'd0, ExRegWrite}, 16'd0);
    nop(); RegWrite1 = 1; RegWriteIndex1 = 4'd7; AluOp1 = 4'd12; RegData11 = 16'h0066;
    step("after_sq");
    check("after_sq.lit", {15'd0, ExRegWrite}, 16'd1);

    // JR overrides branch encoding
    nop(); InsJ1 = 1; InsB1 = 2'b11; Dest1 = 16'h0004; RegReadIndex11 = 4'd1; RegData11 = 16'h1234;
    step("jr");
    nop(); step("jr_slot");

    // Shift / compare
    nop(); AluOp1 = 4'd8; RegData11 = 16'h8000; AluSrc1 = 1; Dest1 = 16'h0003;
    step("sra");
    check("sra.lit", ExResult, 16'hF000);
    nop(); AluOp1 = 4'd9; RegData11 = 16'hFFFF; RegData21 = 16'h0001; RegReadIndex21 = 4'd1;
    step("slt");
    check("slt.lit", ExResult, 16'h0001);
    AluOp1 = 4'd10; step("sltu");
    check("sltu.lit", ExResult, 16'h0000);
    AluOp1 = 4'd15; step("noop");
    check("noop.lit", ExResult, 16'h0000);

    // Stall during a taken branch, then a single redirect pulse
    nop(); RegWrite1 = 1; RegWriteIndex1 = 4'd3; AluOp1 = 4'd12; RegData11 = 16'hABCD;
    step("pre_stall");
    nop(); InsB1 = 2'b11; PcAddr1 = 16'h0200; Dest1 = 16'h0020; RegWrite1 = 1; RegWriteIndex1 = 4'd8;
    Stall = 1;
    for (int i = 0; i < 3; i++) step("stall");
    check("stall.held", ExResult, 16'hABCD);
    Stall = 0; step("release");
    step("release_slot");

    // Reset while squash armed
    nop(); InsB1 = 2'b11; Dest1 = 16'h0008; RegWrite1 = 1; RegWriteIndex1 = 4'd2; AluOp1 = 4'd12;
    RegData11 = 16'h0042;
    step("pre_rst");
    Rst = 1'b0;
    #1;
    model_clear();
    check_outputs("midrst");
    check("midrst.redirect", {15'd0, Redirect}, 16'd0);
    Rst = 1'b1;
    nop(); RegWrite1 = 1; RegWriteIndex1 = 4'd5; AluOp1 = 4'd12; RegData11 = 16'h0077;
    step("post_rst");
    check("post_rst.lit", {15'd0, ExRegWrite}, 16'd1);

    // Random instruction stream against the model
    for (int n = 0; n < 300; n++) begin
      RegWrite1 = 1'($urandom); MemotoReg1 = 1'($urandom);
      MemWrite1 = 1'($urandom); MemRead1 = 1'($urandom);
      AluOp1 = 4'($urandom); PcAddr1 = 16'($urandom);
      RegData11 = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      RegData21 = 16'($urandom);
      RegReadIndex11 = 4'($urandom_range(0, 3)); RegReadIndex21 = 4'($urandom_range(0, 3));
      RegWriteIndex1 = 4'($urandom_range(0, 3));
      InsJ1 = ($urandom_range(0, 9) == 0);
      InsB1 = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      AluSrc1 = 1'($urandom); Dest1 = 16'($urandom);
      WbRegWrite = 1'($urandom); WbIndex = 4'($urandom_range(0, 3)); WbData = 16'($urandom);
      Stall = ($urandom_range(0, 5) == 0);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
